// File: rtl/sseg_pkg.sv
// sseg_pkg -- shared definitions for the seven-segment scan controller.
//
// Contents:
//   GLYPH_TAB    16-entry active-high glyph table, index = nibble value,
//                bit 6..0 = segments g..a (bit 7 unused here, dp is added later)
//   GLYPH_BLANK  glyph for a blanked digit (no segments)
//   GLYPH_DASH   glyph for a dash (segment g only)
//   state_e      controller FSM states
//   seg_byte()   merges a glyph with its decimal point and inverts to the
//                active-low form the display wants
package sseg_pkg;

  // Element 0 is the rightmost entry of the concatenation, so the list runs F..0.
  localparam logic [15:0][7:0] GLYPH_TAB = {
    8'h71, 8'h79, 8'h5E, 8'h58, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h27, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Active-low digit byte: bit 7 = dp, bits 6..0 = g..a.
  function automatic logic [7:0] seg_byte(input logic [7:0] glyph, input logic dp);
    return ~(glyph | {dp, 7'b000_0000});
  endfunction

endpackage

// File: rtl/sseg_blink_timer.sv
// sseg_blink_timer -- blink phase generator.
//
// A prescaler counts 0..BLINK_DIV-1 while en is high; the phase flop toggles
// every time the prescaler wraps. Dropping en clears both, so every blink
// session starts from a known "visible" half-period.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   en     in   run the prescaler
//   phase  out  current blink phase (1 = blinked digits dark)
//
// Parameters:
//   BLINK_DIV  clk cycles per phase, minimum 2
module sseg_blink_timer #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl -- display-update controller for a bank of active-low
// seven-segment digits.
//
// A write captures the whole value into shadow registers, then one digit
// per cycle (most significant first) goes through a single glyph encoder
// into staging registers. After the last digit, staging is copied into the
// display registers in one cycle so a half-updated value is never shown.
// Leading-zero blanking, per-digit decimal points and per-digit blink are
// layered on top of the plain hex decode.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   wr_valid     in   write request
//   wr_ready     out  idle and able to accept a write
//   wr_data      in   one nibble per digit, digit 0 = bits [3:0] (rightmost)
//   wr_dp        in   decimal point per digit
//   wr_blank_lz  in   blank leading zeros
//   wr_dec       in   (only with SSEG_SCAN_CTRL_DEC_MODE_EN) decimal mode:
//                     nibbles A..F render as a dash
//   blink_en     in   global blink enable
//   blink_mask   in   digits subject to blink
//   hex_out      out  active-low segments, byte i = digit i,
//                     bit 7 = dp, bits 6..0 = g..a
//
// Parameters:
//   NDIG       number of digits
//   BLINK_DIV  clk cycles per blink phase (minimum 2)
//
// Build option:
//   SSEG_SCAN_CTRL_DEC_MODE_EN  adds the wr_dec port and decimal-mode dashes.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4*NDIG-1:0] wr_data,
  input  logic [NDIG-1:0]   wr_dp,
  input  logic              wr_blank_lz,
`ifdef SSEG_SCAN_CTRL_DEC_MODE_EN
  input  logic              wr_dec,
`endif
  input  logic              blink_en,
  input  logic [NDIG-1:0]   blink_mask,
  output logic [8*NDIG-1:0] hex_out
);

  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic                   lz_active_q, lz_active_d;
  logic [NDIG-1:0][3:0]   sh_data_q, sh_data_d;
  logic [NDIG-1:0]        sh_dp_q, sh_dp_d;
  logic                   sh_lz_q, sh_lz_d;
`ifdef SSEG_SCAN_CTRL_DEC_MODE_EN
  logic                   sh_dec_q, sh_dec_d;
`endif
  logic [NDIG-1:0][7:0]   stage_q, stage_d;
  logic [NDIG-1:0][7:0]   disp_q, disp_d;
  logic [NDIG-1:0][7:0]   hex_q, hex_d;

  logic                   blink_phase;
  logic [3:0]             nib;
  logic [7:0]             glyph;
  logic                   blank;

  sseg_blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk   (clk),
    .rst   (rst),
    .en    (blink_en),
    .phase (blink_phase)
  );

  assign wr_ready = (state_q == IDLE);

  // Scan FSM plus the shared glyph encoder.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lz_active_d = lz_active_q;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    sh_lz_d     = sh_lz_q;
`ifdef SSEG_SCAN_CTRL_DEC_MODE_EN
    sh_dec_d    = sh_dec_q;
`endif
    stage_d     = stage_q;
    disp_d      = disp_q;
    nib         = sh_data_q[idx_q];
    glyph       = GLYPH_TAB[nib];
    blank       = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          sh_data_d   = wr_data;
          sh_dp_d     = wr_dp;
          sh_lz_d     = wr_blank_lz;
`ifdef SSEG_SCAN_CTRL_DEC_MODE_EN
          sh_dec_d    = wr_dec;
`endif
          idx_d       = IDXW'(NDIG - 1);
          lz_active_d = 1'b1;
          state_d     = SCAN;
        end
      end

      SCAN: begin
        // Digit 0 is exempt so an all-zero value still shows a single "0".
        blank = sh_lz_q && lz_active_q && (nib == 4'd0) && (idx_q != '0);
`ifdef SSEG_SCAN_CTRL_DEC_MODE_EN
        if (sh_dec_q && (nib > 4'd9)) glyph = GLYPH_DASH;
`endif
        if (blank) glyph = GLYPH_BLANK;
        stage_d[idx_q] = seg_byte(glyph, sh_dp_q[idx_q]);
        if (nib != 4'd0) lz_active_d = 1'b0;
        if (idx_q == '0) state_d = COMMIT;
        else             idx_d   = idx_q - 1'b1;
      end

      COMMIT: begin
        disp_d  = stage_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Blink overlay; mask and enable are used live so changes show next edge.
  always_comb begin
    hex_d = disp_q;
    for (int i = 0; i < NDIG; i++) begin
      if (blink_en && blink_phase && blink_mask[i]) hex_d[i] = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lz_active_q <= 1'b0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_lz_q     <= 1'b0;
`ifdef SSEG_SCAN_CTRL_DEC_MODE_EN
      sh_dec_q    <= 1'b0;
`endif
      stage_q     <= '1;
      disp_q      <= '1;
      hex_q       <= '1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lz_active_q <= lz_active_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      sh_lz_q     <= sh_lz_d;
`ifdef SSEG_SCAN_CTRL_DEC_MODE_EN
      sh_dec_q    <= sh_dec_d;
`endif
      stage_q     <= stage_d;
      disp_q      <= disp_d;
      hex_q       <= hex_d;
    end
  end

  assign hex_out = hex_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl (NDIG=4, BLINK_DIV=8). Directed scenarios followed
// by randomized traffic; a reference model turns accepted writes into
// expected display words queued with the edge at which they land, and a
// monitor compares hex_out / wr_ready after every clock edge.
module tb_sseg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int DIV  = 8;

  logic        clk, rst;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic        wr_blank_lz;
  logic        blink_en;
  logic [3:0]  blink_mask;
  logic [31:0] hex_out;
  logic        dec_s;
`ifdef SSEG_SCAN_CTRL_DEC_MODE_EN
  logic        wr_dec;
  assign dec_s = wr_dec;
`else
  assign dec_s = 1'b0;
`endif

  sseg_scan_ctrl #(.NDIG(NDIG), .BLINK_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_dp       (wr_dp),
    .wr_blank_lz (wr_blank_lz),
`ifdef SSEG_SCAN_CTRL_DEC_MODE_EN
    .wr_dec      (wr_dec),
`endif
    .blink_en    (blink_en),
    .blink_mask  (blink_mask),
    .hex_out     (hex_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Active-high glyphs, index = nibble.
  logic [7:0] gtab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h27,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h58, 8'h5E, 8'h79, 8'h71};

  function automatic logic [31:0] ref_word(input logic [15:0] d, input logic [3:0] dp,
                                           input logic lz, input logic dec);
    logic [31:0] w;
    logic [7:0]  g;
    logic [3:0]  n;
    bit          seen;
    seen = 0;
    w    = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      n = d[i*4 +: 4];
      if (lz && !seen && n == 4'd0 && i != 0) g = 8'h00;
      else if (dec && n > 4'd9)               g = 8'h40;
      else                                    g = gtab[n];
      if (n != 4'd0) seen = 1;
      w[i*8 +: 8] = ~(g | {dp[i], 7'b0});
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 30) $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  typedef struct {
    logic [31:0] w;
    int          due;
  } pend_t;

  pend_t       pq[$];
  int          cyc = 0;
  int          busy_until = 0;
  int          k = 0;
  bit          armed = 0;
  logic [31:0] m_disp, exp_hex;
  logic        exp_ready;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      armed      = 1;
      pq.delete();
      m_disp     = '1;
      exp_hex    = '1;
      busy_until = 0;
      k          = 0;
      exp_ready  = 1'b1;
    end else if (armed) begin
      for (int i = 0; i < NDIG; i++)
        exp_hex[i*8 +: 8] = (blink_en && ((k / DIV) % 2 == 1) && blink_mask[i])
                            ? 8'hFF : m_disp[i*8 +: 8];
      if (pq.size() > 0 && pq[0].due == cyc) m_disp = pq.pop_front().w;
      if (wr_valid && exp_ready) begin
        pq.push_back('{ref_word(wr_data, wr_dp, wr_blank_lz, dec_s), cyc + NDIG + 1});
        busy_until = cyc + NDIG + 1;
      end
      exp_ready = (cyc >= busy_until);
      k = blink_en ? k + 1 : 0;
    end
    if (armed) begin
      #3;
      check("hex_out", hex_out, exp_hex);
      check("wr_ready", {31'b0, wr_ready}, {31'b0, exp_ready});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] dp, input logic lz,
                       input bit hold);
    bit got;
    got = 0;
    wr_valid = 1'b1; wr_data = d; wr_dp = dp; wr_blank_lz = lz;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (wr_ready) got = 1;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: wr_ready never seen, data %h", d);
    end
    if (!hold) wr_valid = 1'b0;
  endtask

  function automatic logic [15:0] rnd_data();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[i*4 +: 4] = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom % 16);
    return d;
  endfunction

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_dp = '0; wr_blank_lz = 1'b0;
    blink_en = 1'b0; blink_mask = '0;
`ifdef SSEG_SCAN_CTRL_DEC_MODE_EN
    wr_dec = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    write(16'h1234, 4'b0000, 1'b0, 0);   idle(10);
    write(16'h00E0, 4'b0001, 1'b1, 0);   idle(8);
    write(16'h0000, 4'b0000, 1'b1, 0);   idle(8);
    write(16'hAAAA, 4'b0000, 1'b0, 1);
    write(16'h5555, 4'b0000, 1'b0, 0);   idle(8);

    blink_en = 1'b1; blink_mask = 4'b1000;
    write(16'h1234, 4'b0000, 1'b0, 0);   idle(40);
    blink_en = 1'b0;                     idle(3);

    write(16'h8888, 4'b0000, 1'b0, 0);   idle(2);
    rst = 1'b1;                          idle(1);
    rst = 1'b0;
    write(16'h1234, 4'b0000, 1'b0, 0);   idle(8);

    for (int c = 0; c < 3000; c++) begin
      wr_valid    = ($urandom % 3 == 0);
      wr_data     = rnd_data();
      wr_dp       = 4'($urandom);
      wr_blank_lz = 1'($urandom);
`ifdef SSEG_SCAN_CTRL_DEC_MODE_EN
      wr_dec      = 1'($urandom);
`endif
      if ($urandom % 20 == 0) blink_en   = ~blink_en;
      if ($urandom % 30 == 0) blink_mask = 4'($urandom);
      rst = ($urandom % 250 == 0);
      idle(1);
    end
    rst = 1'b0; wr_valid = 1'b0;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
